// File: rtl/b_a_4.sv
// b_a_4: 4-bit ripple-carry adder slice with carry-in/carry-out.
// The sum, carry and overflow paths are purely combinational so that a
// cascade of slices settles in a single evaluation. Registered copies
// of the same results are provided for pipelined consumers.
//
// Ports (declaration order is fixed; the first five stay
// positional-compatible with legacy (s, c_out, a, b, c_in) instances):
//   s        out [3:0]  combinational sum, (a + b + c_in) mod 16
//   c_out    out        combinational carry out of bit 3
//   a, b     in  [3:0]  unsigned addends
//   c_in     in         carry-in
//   clk      in         rising-edge clock for the registered copies
//   rst      in         asynchronous active-high reset for the registered copies
//   ovf      out        combinational signed overflow, carry into bit 3 ^ carry out of bit 3
//   s_q      out [3:0]  s registered on clk
//   c_out_q  out        c_out registered on clk
//   ovf_q    out        ovf registered on clk
module b_a_4 (
    output logic [3:0] s,
    output logic       c_out,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       c_in,
    input  logic       clk,
    input  logic       rst,
    output logic       ovf,
    output logic [3:0] s_q,
    output logic       c_out_q,
    output logic       ovf_q
);

    localparam int unsigned W = 4;

    // c[i] is the carry into cell i; c[W] is the carry out of the slice.
    logic [W:0] c;

    // Ripple chain of full-adder cells.
    always_comb begin
        c    = '0;
        s    = '0;
        c[0] = c_in;
        for (int unsigned i = 0; i < W; i++) begin
            s[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1] = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
    end

    assign c_out = c[W];
    assign ovf   = c[W-1] ^ c[W];

    logic [3:0] s_d;
    logic       c_out_d;
    logic       ovf_d;

    assign s_d     = s;
    assign c_out_d = c_out;
    assign ovf_d   = ovf;

    // Unconditional capture every cycle; reset clears the registered copies.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s_q     <= 4'h0;
            c_out_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            s_q     <= s_d;
            c_out_q <= c_out_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_b_a_4.sv
// Testbench for b_a_4: directed cases, exhaustive combinational sweep,
// randomized registered-path checks, 16-bit cascade, and reset behaviour.
module tb_b_a_4;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic       c_in;
    logic [3:0] s;
    logic       c_out;
    logic       ovf;
    logic [3:0] s_q;
    logic       c_out_q;
    logic       ovf_q;

    int pass_cnt;
    int total_cnt;

    b_a_4 dut (
        .s(s), .c_out(c_out), .a(a), .b(b), .c_in(c_in),
        .clk(clk), .rst(rst), .ovf(ovf),
        .s_q(s_q), .c_out_q(c_out_q), .ovf_q(ovf_q)
    );

    // 16-bit cascade of four slices
    logic [15:0] a16;
    logic [15:0] b16;
    logic        cin16;
    logic [15:0] s16;
    logic [4:0]  cc;
    logic [3:0]  cs_q  [4];
    logic [3:0]  cco_q;
    logic [3:0]  cov;
    logic [3:0]  cov_q;

    assign cc[0] = cin16;

    for (genvar g = 0; g < 4; g++) begin : g_casc
        b_a_4 u_slice (
            .s(s16[4*g +: 4]), .c_out(cc[g+1]),
            .a(a16[4*g +: 4]), .b(b16[4*g +: 4]), .c_in(cc[g]),
            .clk(clk), .rst(rst), .ovf(cov[g]),
            .s_q(cs_q[g]), .c_out_q(cco_q[g]), .ovf_q(cov_q[g])
        );
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovf, c_out, s} from integer arithmetic on the operands.
    function automatic logic [5:0] model(input logic [3:0] ma, input logic [3:0] mb,
                                         input logic mc);
        int u;
        int sa;
        int sb;
        int sg;
        logic v;
        u  = int'(ma) + int'(mb) + int'(mc);
        sa = ma[3] ? int'(ma) - 16 : int'(ma);
        sb = mb[3] ? int'(mb) - 16 : int'(mb);
        sg = sa + sb + int'(mc);
        v  = (sg > 7) || (sg < -8);
        return {v, 5'(u)};
    endfunction

    task automatic test_reset();
        rst = 1'b1; a = 4'h3; b = 4'h4; c_in = 1'b0;
        #1;
        total_cnt++;
        if ({s_q, c_out_q, ovf_q} !== 6'b0) $display("FAIL reset_regs got=%b exp=000000", {s_q, c_out_q, ovf_q});
        else pass_cnt++;
        total_cnt++;
        if ({ovf, c_out, s} !== 6'b000111) $display("FAIL reset_comb_live got=%b exp=000111", {ovf, c_out, s});
        else pass_cnt++;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [3:0] ta [3];
        logic [3:0] tb_ [3];
        logic       tc [3];
        logic [5:0] te [3];
        ta[0] = 4'hF; tb_[0] = 4'h1; tc[0] = 1'b0; te[0] = 6'b0_1_0000;
        ta[1] = 4'h1; tb_[1] = 4'h7; tc[1] = 1'b1; te[1] = 6'b1_0_1001;
        ta[2] = 4'hF; tb_[2] = 4'hF; tc[2] = 1'b1; te[2] = 6'b0_1_1111;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            a = ta[i]; b = tb_[i]; c_in = tc[i];
            #1;
            total_cnt++;
            if ({ovf, c_out, s} !== te[i]) $display("FAIL directed_%0d got=%b exp=%b", i, {ovf, c_out, s}, te[i]);
            else pass_cnt++;
            @(posedge clk); #1;
            total_cnt++;
            if ({ovf_q, c_out_q, s_q} !== te[i]) $display("FAIL directed_reg_%0d got=%b exp=%b", i, {ovf_q, c_out_q, s_q}, te[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_sweep();
        logic [5:0] e;
        int errs;
        errs = 0;
        @(negedge clk);
        for (int i = 0; i < 512; i++) begin
            a = 4'(i); b = 4'(i >> 4); c_in = 1'(i >> 8);
            #0.5;
            e = model(a, b, c_in);
            total_cnt++;
            if ({ovf, c_out, s} !== e) begin
                if (errs < 8) $display("FAIL sweep a=%h b=%h ci=%b got=%b exp=%b", a, b, c_in, {ovf, c_out, s}, e);
                errs++;
            end else pass_cnt++;
        end
    endtask

    task automatic test_random_registered();
        logic [5:0] e;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            a = 4'($urandom); b = 4'($urandom); c_in = 1'($urandom);
            e = model(a, b, c_in);
            @(posedge clk); #1;
            a = 4'($urandom); b = 4'($urandom); c_in = 1'($urandom);
            total_cnt++;
            if ({ovf_q, c_out_q, s_q} !== e) $display("FAIL rand_reg_%0d got=%b exp=%b", i, {ovf_q, c_out_q, s_q}, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_cascade();
        logic [16:0] e;
        a16 = 16'h001F; b16 = 16'h2B71; cin16 = 1'b0;
        #1;
        total_cnt++;
        if ({cc[4], s16} !== 17'h02B90) $display("FAIL cascade_sum got=%h exp=02b90", {cc[4], s16});
        else pass_cnt++;
        total_cnt++;
        if (cc[3:1] !== 3'b001) $display("FAIL cascade_nibble_carries got=%b exp=001", cc[3:1]);
        else pass_cnt++;
        for (int i = 0; i < 30; i++) begin
            a16 = 16'($urandom); b16 = 16'($urandom); cin16 = 1'($urandom);
            if (i == 0) begin a16 = 16'hFFFF; b16 = 16'h0000; cin16 = 1'b1; end
            #1;
            e = 17'(int'(a16) + int'(b16) + int'(cin16));
            total_cnt++;
            if ({cc[4], s16} !== e) $display("FAIL cascade_rand_%0d got=%h exp=%h", i, {cc[4], s16}, e);
            else pass_cnt++;
        end
    endtask

    task automatic test_async_reset();
        @(negedge clk);
        a = 4'h8; b = 4'h8; c_in = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if ({ovf_q, c_out_q, s_q} !== 6'b1_1_0000) $display("FAIL async_preload got=%b exp=110000", {ovf_q, c_out_q, s_q});
        else pass_cnt++;
        #2;
        rst = 1'b1;
        #1;
        total_cnt++;
        if ({ovf_q, c_out_q, s_q} !== 6'b0) $display("FAIL async_clear got=%b exp=000000", {ovf_q, c_out_q, s_q});
        else pass_cnt++;
        total_cnt++;
        if ({ovf, c_out, s} !== 6'b1_1_0000) $display("FAIL async_comb_hold got=%b exp=110000", {ovf, c_out, s});
        else pass_cnt++;
        #1;
        rst = 1'b0;
    endtask

    task automatic test_reset_hold();
        logic [5:0] e;
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 4; i++) begin
            a = 4'($urandom) | 4'h1; b = 4'hF; c_in = 1'b1;
            @(posedge clk); #1;
            total_cnt++;
            if ({ovf_q, c_out_q, s_q} !== 6'b0) $display("FAIL reset_hold_%0d got=%b exp=000000", i, {ovf_q, c_out_q, s_q});
            else pass_cnt++;
            @(negedge clk);
        end
        a = 4'h5; b = 4'h6; c_in = 1'b1;
        e = model(a, b, c_in);
        rst = 1'b0;
        @(posedge clk); #1;
        total_cnt++;
        if ({ovf_q, c_out_q, s_q} !== e) $display("FAIL reset_release got=%b exp=%b", {ovf_q, c_out_q, s_q}, e);
        else pass_cnt++;
    endtask

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        rst = 1'b0; a = 4'h0; b = 4'h0; c_in = 1'b0;
        a16 = 16'h0; b16 = 16'h0; cin16 = 1'b0;
        test_reset();
        test_directed();
        test_sweep();
        test_random_registered();
        test_cascade();
        test_async_reset();
        test_reset_hold();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

endmodule
